// File: rtl/base_components_pkg.sv
// Shared definitions for the serialiser blocks: FSM state type, the serial
// line idle level and the bit-counter width helper.
package base_components_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shiftStateT;

  // Level driven on the serial line whenever no frame is in flight.
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter must reach WIDTH (parity slot) without wrapping.
  function automatic int counterWidth(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/piso_shift_reg_bit_counter.sv
// Saturating up-counter for the serialiser: synchronous clear, enable and a
// terminal flag once the count reaches LIMIT. Holding at LIMIT keeps the
// count from wrapping inside a frame.
module bit_counter #(
  parameter int CW    = 4,
  parameter int LIMIT = 7
) (
  input  logic          clkIn,
  input  logic          rstIn,
  input  logic          clrIn,
  input  logic          enIn,
  output logic [CW-1:0] countOut,
  output logic          termOut
);

  assign termOut = (countOut == CW'(LIMIT));

  // Clear wins over counting; counting stops at the terminal value.
  always_ff @(posedge clkIn) begin
    if (rstIn || clrIn) begin
      countOut <= '0;
    end else if (enIn && !termOut) begin
      countOut <= countOut + CW'(1);
    end
  end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first, idle line high.
// Optional macro PISO_PARITY_EN appends one even-parity bit after the data.
//
// state | meaning
// IDLE  | line at idle level, readyOut high, a load may be accepted
// SHIFT | frame in flight, one bit per enabled cycle, loads ignored
module piso_shift_reg
  import base_components_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             enIn,
  input  logic             loadIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic             serialOut,
  output logic             serialNotOut,
  output logic             readyOut,
  output logic             busyOut,
  output logic             doneOut
);

  localparam int CW = counterWidth(WIDTH);
`ifdef PISO_PARITY_EN
  localparam int LAST_BIT = WIDTH;
`else
  localparam int LAST_BIT = WIDTH - 1;
`endif

  shiftStateT       state;
  logic [WIDTH-1:0] shiftReg;
  logic [CW-1:0]    bitCount;
  logic             countTerm;
  logic             loadAccept;
  logic             countEn;
`ifdef PISO_PARITY_EN
  logic             parityBit;
`endif

  assign loadAccept = enIn && (state == IDLE) && loadIn;
  assign countEn    = enIn && (state == SHIFT);

  bit_counter #(
    .CW    (CW),
    .LIMIT (LAST_BIT)
  ) uBitCounter (
    .clkIn    (clkIn),
    .rstIn    (rstIn),
    .clrIn    (loadAccept),
    .enIn     (countEn),
    .countOut (bitCount),
    .termOut  (countTerm)
  );

  // shiftReg holds the bits still to be sent after the one currently on the line.
  // FSM, shift register and all registered outputs.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state        <= IDLE;
      shiftReg     <= '0;
      serialOut    <= IDLE_LEVEL;
      serialNotOut <= ~IDLE_LEVEL;
      readyOut     <= 1'b1;
      busyOut      <= 1'b0;
      doneOut      <= 1'b0;
`ifdef PISO_PARITY_EN
      parityBit    <= 1'b0;
`endif
    end else begin
      doneOut <= 1'b0;
      if (enIn) begin
        case (state)
          IDLE: begin
            if (loadIn) begin
              state        <= SHIFT;
              shiftReg     <= dataIn >> 1;
              serialOut    <= dataIn[0];
              serialNotOut <= ~dataIn[0];
              readyOut     <= 1'b0;
              busyOut      <= 1'b1;
`ifdef PISO_PARITY_EN
              parityBit    <= ^dataIn;
`endif
            end
          end
          SHIFT: begin
            if (countTerm) begin
              state        <= IDLE;
              serialOut    <= IDLE_LEVEL;
              serialNotOut <= ~IDLE_LEVEL;
              readyOut     <= 1'b1;
              busyOut      <= 1'b0;
              doneOut      <= 1'b1;
            end else begin
`ifdef PISO_PARITY_EN
              if (bitCount == CW'(WIDTH - 1)) begin
                serialOut    <= parityBit;
                serialNotOut <= ~parityBit;
              end else
`endif
              begin
                serialOut    <= shiftReg[0];
                serialNotOut <= ~shiftReg[0];
              end
              shiftReg <= shiftReg >> 1;
            end
          end
        endcase
      end
    end
  end

  // The bit counter saturates at the last slot; it must never pass it.
  countNoWrap: assert property (@(posedge clkIn) disable iff (rstIn)
    bitCount <= CW'(LAST_BIT));

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg. Expected serial streams come from
// the data word itself (bit i of the frame, plus even parity when
// PISO_PARITY_EN is defined) indexed by the count of enabled edges since load.
module tb_piso_shift_reg;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif

  logic             clkIn = 1'b0;
  logic             rstIn;
  logic             enIn;
  logic             loadIn;
  logic [WIDTH-1:0] dataIn;
  logic             serialOut;
  logic             serialNotOut;
  logic             readyOut;
  logic             busyOut;
  logic             doneOut;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clkIn = ~clkIn;

  piso_shift_reg #(.WIDTH(WIDTH)) dut (
    .clkIn        (clkIn),
    .rstIn        (rstIn),
    .enIn         (enIn),
    .loadIn       (loadIn),
    .dataIn       (dataIn),
    .serialOut    (serialOut),
    .serialNotOut (serialNotOut),
    .readyOut     (readyOut),
    .busyOut      (busyOut),
    .doneOut      (doneOut)
  );

  // Bit i of a frame: data bits LSB first, then parity (ones count made even).
  function automatic logic frame_bit(input logic [WIDTH-1:0] d, input int i);
    if (i < WIDTH) return d[i];
    return ^d;
  endfunction

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  // Load d now and follow the frame to its done cycle.
  // mode 0: enable always high; 1: enable dropped 3 edges while bit 3 is out; 2: random.
  task automatic run_frame(input logic [WIDTH-1:0] d, input int mode, input bit intrude,
                           input logic [WIDTH-1:0] junk, input string tag, output int doneCyc);
    int   n    = 0;
    int   held = 0;
    int   cyc  = 0;
    logic en;
    logic expS;
    loadIn = 1'b1;
    dataIn = d;
    enIn   = 1'b1;
    tick();
    cyc = 1;
    while (n < FLEN) begin
      expS = frame_bit(d, n);
      nChecks++;
      if (serialOut !== expS || serialNotOut !== ~expS || readyOut !== 1'b0 ||
          busyOut !== 1'b1 || doneOut !== 1'b0) begin
        nFails++;
        $display("FAIL %s bit%0d cyc%0d: got ser=%b nser=%b rdy=%b busy=%b done=%b, want ser=%b nser=%b rdy=0 busy=1 done=0",
                 tag, n, cyc, serialOut, serialNotOut, readyOut, busyOut, doneOut, expS, ~expS);
      end
      case (mode)
        0:       en = 1'b1;
        1:       en = !(n == 3 && held < 3);
        default: en = ($urandom_range(0, 3) != 0);
      endcase
      if (!en) held++;
      enIn   = en;
      loadIn = intrude;
      dataIn = intrude ? junk : d;
      tick();
      cyc++;
      if (en) n++;
      if (cyc > 400) begin
        nChecks++;
        nFails++;
        $display("FAIL %s timeout: got no done after %0d cycles, want done", tag, cyc);
        doneCyc = cyc;
        return;
      end
    end
    loadIn = 1'b0;
    nChecks++;
    if (serialOut !== 1'b1 || serialNotOut !== 1'b0 || readyOut !== 1'b1 ||
        busyOut !== 1'b0 || doneOut !== 1'b1) begin
      nFails++;
      $display("FAIL %s done cyc%0d: got ser=%b nser=%b rdy=%b busy=%b done=%b, want ser=1 nser=0 rdy=1 busy=0 done=1",
               tag, cyc, serialOut, serialNotOut, readyOut, busyOut, doneOut);
    end
    doneCyc = cyc;
  endtask

  task automatic test_reset();
    rstIn  = 1'b1;
    enIn   = 1'b1;
    loadIn = 1'b1;
    dataIn = 8'h00;
    tick();
    tick();
    nChecks++; if (serialOut !== 1'b1)    begin nFails++; $display("FAIL reset_ser: got %b want 1", serialOut); end
    nChecks++; if (serialNotOut !== 1'b0) begin nFails++; $display("FAIL reset_nser: got %b want 0", serialNotOut); end
    nChecks++; if (readyOut !== 1'b1)     begin nFails++; $display("FAIL reset_ready: got %b want 1", readyOut); end
    nChecks++; if (busyOut !== 1'b0)      begin nFails++; $display("FAIL reset_busy: got %b want 0", busyOut); end
    nChecks++; if (doneOut !== 1'b0)      begin nFails++; $display("FAIL reset_done: got %b want 0", doneOut); end
    rstIn  = 1'b0;
    loadIn = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int dc;
    int expDc;
`ifdef PISO_PARITY_EN
    run_frame(8'h07, 0, 1'b0, 8'h00, "basic_07", dc);
    expDc = 10;
`else
    run_frame(8'hA5, 0, 1'b0, 8'h00, "basic_A5", dc);
    expDc = 9;
`endif
    nChecks++;
    if (dc !== expDc) begin nFails++; $display("FAIL basic_done_cycle: got %0d want %0d", dc, expDc); end
    enIn   = 1'b0;
    loadIn = 1'b0;
    tick();
    nChecks++;
    if (doneOut !== 1'b0 || serialOut !== 1'b1 || readyOut !== 1'b1) begin
      nFails++;
      $display("FAIL done_clear_en0: got done=%b ser=%b rdy=%b want done=0 ser=1 rdy=1", doneOut, serialOut, readyOut);
    end
  endtask

  task automatic test_enable_hold();
    int dc;
    int expDc;
`ifdef PISO_PARITY_EN
    expDc = 13;
`else
    expDc = 12;
`endif
    run_frame(8'hA5, 1, 1'b0, 8'h00, "hold_A5", dc);
    nChecks++;
    if (dc !== expDc) begin nFails++; $display("FAIL hold_done_cycle: got %0d want %0d", dc, expDc); end
    enIn = 1'b1;
    tick();
  endtask

  task automatic test_ignore_load();
    int dc;
    run_frame(8'hA5, 0, 1'b1, 8'hFF, "ignore_FF", dc);
    enIn   = 1'b1;
    loadIn = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int dc;
    run_frame(8'hA5, 0, 1'b0, 8'h00, "b2b_first", dc);
    run_frame(8'h3C, 0, 1'b0, 8'h00, "b2b_3C", dc);
    enIn = 1'b1;
    tick();
  endtask

  task automatic test_enable_idle();
    enIn   = 1'b0;
    loadIn = 1'b1;
    dataIn = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++;
      if (readyOut !== 1'b1 || busyOut !== 1'b0 || serialOut !== 1'b1) begin
        nFails++;
        $display("FAIL idle_en0_load: got rdy=%b busy=%b ser=%b want rdy=1 busy=0 ser=1", readyOut, busyOut, serialOut);
      end
    end
    loadIn = 1'b0;
    enIn   = 1'b1;
  endtask

  task automatic test_reset_midframe();
    loadIn = 1'b1;
    dataIn = 8'hA5;
    enIn   = 1'b1;
    tick();
    loadIn = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    nChecks++;
    if (serialOut !== frame_bit(8'hA5, 5)) begin
      nFails++;
      $display("FAIL midframe_bit5: got %b want %b", serialOut, frame_bit(8'hA5, 5));
    end
    rstIn  = 1'b1;
    loadIn = 1'b1;
    tick();
    nChecks++;
    if (serialOut !== 1'b1 || readyOut !== 1'b1 || busyOut !== 1'b0 || doneOut !== 1'b0) begin
      nFails++;
      $display("FAIL midframe_reset: got ser=%b rdy=%b busy=%b done=%b want ser=1 rdy=1 busy=0 done=0",
               serialOut, readyOut, busyOut, doneOut);
    end
    rstIn  = 1'b0;
    loadIn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      nChecks++;
      if (doneOut !== 1'b0 || serialOut !== 1'b1 || readyOut !== 1'b1) begin
        nFails++;
        $display("FAIL midframe_after cyc%0d: got done=%b ser=%b rdy=%b want done=0 ser=1 rdy=1",
                 i, doneOut, serialOut, readyOut);
      end
    end
  endtask

  task automatic test_random();
    int dc;
    int gap;
    for (int f = 0; f < 30; f++) begin
      run_frame(WIDTH'($urandom), 2, 1'($urandom_range(0, 1)), WIDTH'($urandom), "random", dc);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        enIn   = 1'($urandom_range(0, 1));
        loadIn = 1'b0;
        tick();
        nChecks++;
        if (doneOut !== 1'b0 || serialOut !== 1'b1 || readyOut !== 1'b1 || busyOut !== 1'b0) begin
          nFails++;
          $display("FAIL random_gap f%0d g%0d: got done=%b ser=%b rdy=%b busy=%b want done=0 ser=1 rdy=1 busy=0",
                   f, g, doneOut, serialOut, readyOut, busyOut);
        end
      end
    end
  endtask

  initial begin
    rstIn  = 1'b1;
    enIn   = 1'b0;
    loadIn = 1'b0;
    dataIn = '0;
    test_reset();
    test_basic();
    test_enable_hold();
    test_ignore_load();
    test_back_to_back();
    test_enable_idle();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
